seg_scroll_display: RTL

Parametrised multiplexed seven-segment text display for the Morse trainer. It accepts decoded ASCII characters as single-cycle strobes and stores them, already encoded, in an N-slot buffer. It time-multiplexes the buffer onto one shared active-low segment bus and N active-low digit enables. Compared with the fixed 8-digit display it adds configurable digit count and refresh rate, a fully synchronous strobe interface, backspace, clear, a scroll mode, and occupancy/overflow status.

---
 rtl/seg_scroll_display_if.sv | 25 ++
 rtl/seg_scroll_display.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seg_scroll_display_if.sv
// Character strobe bus for the seven-segment text display.
// The master drives characters and edit strobes; the display is the slave.
interface seg_scroll_display_if;
   logic [7:0] ascii_char;
   logic       char_valid;
   logic       backspace;
   logic       clear;
   logic       mode;

   modport master (
      output ascii_char,
      output char_valid,
      output backspace,
      output clear,
      output mode
   );

   modport slave (
      input ascii_char,
      input char_valid,
      input backspace,
      input clear,
      input mode
   );
endinterface

// File: rtl/seg_scroll_display.sv
// Multiplexed seven-segment text display with an N-slot encoded buffer.
// Supports fill/scroll modes, backspace, clear and occupancy/overflow status.
module seg_scroll_display #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 10000,
   localparam int CW = $clog2(NUM_DIGITS + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   seg_scroll_display_if.slave   bus,
   output logic [6:0]            seg_out,
   output logic [NUM_DIGITS-1:0] an_out,
   output logic [CW-1:0]         char_count,
   output logic                  full,
   output logic                  overflow
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic [6:0]    slot [NUM_DIGITS];
   logic [IW-1:0] idx;
   logic [PW-1:0] pre;
   logic [6:0]    pat;

   // Active-low a..g pattern; lower case folds onto upper case.
   function automatic logic [6:0] encode(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
      case (u)
         "0": encode = 7'b0000001;
         "1": encode = 7'b1001111;
         "2": encode = 7'b0010010;
         "3": encode = 7'b0000110;
         "4": encode = 7'b1001100;
         "5": encode = 7'b0100100;
         "6": encode = 7'b0100000;
         "7": encode = 7'b0001111;
         "8": encode = 7'b0000000;
         "9": encode = 7'b0000100;
         "A": encode = 7'b0001000;
         "B": encode = 7'b1100000;
         "C": encode = 7'b0110001;
         "D": encode = 7'b1000010;
         "E": encode = 7'b0110000;
         "F": encode = 7'b0111000;
         "G": encode = 7'b0100001;
         "H": encode = 7'b1001000;
         "I": encode = 7'b1111001;
         "J": encode = 7'b1000011;
         "K": encode = 7'b0101000;
         "L": encode = 7'b1110001;
         "M": encode = 7'b0101010;
         "N": encode = 7'b1101010;
         "O": encode = 7'b0000001;
         "P": encode = 7'b0011000;
         "Q": encode = 7'b0001100;
         "R": encode = 7'b1111010;
         "S": encode = 7'b0101100;
         "T": encode = 7'b1110000;
         "U": encode = 7'b1000001;
         "V": encode = 7'b1100011;
         "W": encode = 7'b1010100;
         "X": encode = 7'b1001000;
         "Y": encode = 7'b1000100;
         "Z": encode = 7'b0010010;
         " ": encode = BLANK;
         default: encode = 7'b1111110;
      endcase
   endfunction

   assign pat  = encode(bus.ascii_char);
   assign full = (char_count == CW'(NUM_DIGITS));

   // Buffer edits: clear beats backspace beats a new character.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < NUM_DIGITS; k++) slot[k] <= BLANK;
         char_count <= '0;
         overflow   <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (bus.clear) begin
            for (int k = 0; k < NUM_DIGITS; k++) slot[k] <= BLANK;
            char_count <= '0;
         end else if (bus.backspace) begin
            if (char_count != '0) begin
               slot[IW'(char_count - CW'(1))] <= BLANK;
               char_count <= char_count - CW'(1);
            end
         end else if (bus.char_valid) begin
            if (!full) begin
               slot[IW'(char_count)] <= pat;
               char_count <= char_count + CW'(1);
            end else if (bus.mode) begin
               for (int k = 0; k < NUM_DIGITS - 1; k++) slot[k] <= slot[k+1];
               slot[NUM_DIGITS-1] <= pat;
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end

   // Refresh prescaler and digit index advance.
   always_ff @(posedge clock) begin
      if (reset) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PW'(REFRESH_DIV - 1)) begin
         pre <= '0;
         if (idx == IW'(NUM_DIGITS - 1)) idx <= '0;
         else                            idx <= idx + IW'(1);
      end else begin
         pre <= pre + PW'(1);
      end
   end

   // Registered digit enable and segment drive for the current digit.
   always_ff @(posedge clock) begin
      if (reset) begin
         seg_out <= BLANK;
         an_out  <= '1;
      end else begin
         seg_out <= slot[idx];
         an_out  <= ~(NUM_DIGITS'(1) << idx);
      end
   end

endmodule
